ray_sphere_isect_seq: RTL

- Sequential, parametrised ray/sphere hit tester in signed fixed point. It replaces the combinational real-valued intersect test.
- Arbitrary ray origin, sphere centre and radius; one shared multiplier; valid/ready on input and output.
- Optional front-facing mode rejects spheres lying wholly behind the ray origin.
- Feeds the per-pixel shading stage of the ray tracer.

---
 rtl/ray_sphere_isect_seq.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/ray_sphere_isect_seq.sv
// Sequential ray/sphere hit test in signed fixed point, sharing one multiplier.
// The exact discriminant b*b - a*c is reported alongside the hit flag.
//
// state | meaning
// IDLE  | waiting for a request
// SUB   | oc = orig - ctr
// MUL   | 12 shared-multiplier steps build a, b, c, b*b, a*c
// FIN   | register disc, degen, hit
// DONE  | result held until out_ready
module ray_sphere_isect_seq #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16,
    localparam int DW   = 4*WIDTH + 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3*WIDTH-1:0] ray_orig,
    input  logic [3*WIDTH-1:0] ray_dir,
    input  logic [3*WIDTH-1:0] sph_ctr,
    input  logic [WIDTH-1:0]   sph_rad,
    input  logic               front_only,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               hit,
    output logic               degen,
    output logic [DW-1:0]      disc,
    output logic               busy
);
    localparam int AW = 2*WIDTH + 6;
    localparam int OW = WIDTH + 1;

    if (WIDTH < 4 || FRAC < 0 || FRAC >= WIDTH) begin : g_param_check
        $error("ray_sphere_isect_seq: need WIDTH >= 4 and 0 <= FRAC < WIDTH");
    end

    typedef enum logic [2:0] {S_IDLE, S_SUB, S_MUL, S_FIN, S_DONE} state_t;

    state_t                  state;
    logic [3:0]              step;
    logic signed [OW-1:0]    oc_x, oc_y, oc_z;
    logic signed [WIDTH-1:0] ctr_x, ctr_y, ctr_z;
    logic signed [WIDTH-1:0] dir_x, dir_y, dir_z;
    logic signed [WIDTH-1:0] rad;
    logic                    fo;
    logic signed [AW-1:0]    acc_a, acc_b, acc_c;
    logic signed [DW-1:0]    p0, p1;

    logic signed [AW-1:0]    mul_x, mul_y;
    logic signed [DW-1:0]    prod;
    logic signed [DW-1:0]    disc_next;
    logic                    hit_next;
    logic                    accept;

    function automatic logic signed [WIDTH-1:0] comp(input logic [3*WIDTH-1:0] v, input int i);
        return $signed(v[(3-i)*WIDTH-1 -: WIDTH]);
    endfunction

    assign in_ready = (state == S_IDLE) || (state == S_DONE && out_ready);
    assign busy     = (state != S_IDLE);
    assign accept   = in_valid && in_ready;

    always_comb begin
        mul_x = '0;
        mul_y = '0;
        case (step)
            4'd0:  begin mul_x = AW'(dir_x); mul_y = AW'(dir_x); end
            4'd1:  begin mul_x = AW'(dir_y); mul_y = AW'(dir_y); end
            4'd2:  begin mul_x = AW'(dir_z); mul_y = AW'(dir_z); end
            4'd3:  begin mul_x = AW'(oc_x);  mul_y = AW'(dir_x); end
            4'd4:  begin mul_x = AW'(oc_y);  mul_y = AW'(dir_y); end
            4'd5:  begin mul_x = AW'(oc_z);  mul_y = AW'(dir_z); end
            4'd6:  begin mul_x = AW'(oc_x);  mul_y = AW'(oc_x);  end
            4'd7:  begin mul_x = AW'(oc_y);  mul_y = AW'(oc_y);  end
            4'd8:  begin mul_x = AW'(oc_z);  mul_y = AW'(oc_z);  end
            4'd9:  begin mul_x = AW'(rad);   mul_y = AW'(rad);   end
            4'd10: begin mul_x = acc_b;      mul_y = acc_b;      end
            4'd11: begin mul_x = acc_a;      mul_y = acc_c;      end
            default: begin mul_x = '0; mul_y = '0; end
        endcase
        // Every product fits in DW bits, so truncating the wide multiply is exact.
        prod      = DW'(mul_x) * DW'(mul_y);
        disc_next = p0 - p1;
        hit_next  = (acc_a != '0) && !disc_next[DW-1]
                    && (!fo || acc_c[AW-1] || acc_c == '0 || acc_b[AW-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            step      <= '0;
            oc_x      <= '0;
            oc_y      <= '0;
            oc_z      <= '0;
            ctr_x     <= '0;
            ctr_y     <= '0;
            ctr_z     <= '0;
            dir_x     <= '0;
            dir_y     <= '0;
            dir_z     <= '0;
            rad       <= '0;
            fo        <= 1'b0;
            acc_a     <= '0;
            acc_b     <= '0;
            acc_c     <= '0;
            p0        <= '0;
            p1        <= '0;
            out_valid <= 1'b0;
            hit       <= 1'b0;
            degen     <= 1'b0;
            disc      <= '0;
        end else begin
            if (accept) begin
                oc_x  <= OW'(comp(ray_orig, 0));
                oc_y  <= OW'(comp(ray_orig, 1));
                oc_z  <= OW'(comp(ray_orig, 2));
                ctr_x <= comp(sph_ctr, 0);
                ctr_y <= comp(sph_ctr, 1);
                ctr_z <= comp(sph_ctr, 2);
                dir_x <= comp(ray_dir, 0);
                dir_y <= comp(ray_dir, 1);
                dir_z <= comp(ray_dir, 2);
                rad   <= $signed(sph_rad);
                fo    <= front_only;
            end
            case (state)
                S_IDLE: begin
                    if (accept) state <= S_SUB;
                end
                S_SUB: begin
                    oc_x  <= oc_x - OW'(ctr_x);
                    oc_y  <= oc_y - OW'(ctr_y);
                    oc_z  <= oc_z - OW'(ctr_z);
                    acc_a <= '0;
                    acc_b <= '0;
                    acc_c <= '0;
                    step  <= '0;
                    state <= S_MUL;
                end
                S_MUL: begin
                    if (step < 4'd3)       acc_a <= acc_a + $signed(prod[AW-1:0]);
                    else if (step < 4'd6)  acc_b <= acc_b + $signed(prod[AW-1:0]);
                    else if (step < 4'd9)  acc_c <= acc_c + $signed(prod[AW-1:0]);
                    else if (step == 4'd9) acc_c <= acc_c - $signed(prod[AW-1:0]);
                    else if (step == 4'd10) p0   <= prod;
                    else                    p1   <= prod;
                    if (step == 4'd11) begin
                        step  <= '0;
                        state <= S_FIN;
                    end else begin
                        step <= step + 4'd1;
                    end
                end
                S_FIN: begin
                    disc      <= disc_next;
                    degen     <= (acc_a == '0);
                    hit       <= hit_next;
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= accept ? S_SUB : S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
